mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one external single-request memory channel between the two BRAM-style ports (port 0, port 1) of an HLS kernel.
- Replaces clock gating with a stall handshake: `kernel_stall` holds the kernel while its accesses are serviced, serially, port 0 first.
- Sits between the kernel instance and the host read/write interface, inside the kernel wrapper.

Parameters:
- ADDR_WID, 14, width of kernel port word addresses
- DATA_WID, 32, data width
- ADDR_SHIFT, 2, left shift from word address to byte address
- TIMEOUT, 1023, max wait cycles for a memory response before abort

Ports:
- mod_clk  in  1  block clock
- reset  in  1  asynchronous, active-high
- read_base  in  64  byte base for reads
- write_base  in  64  byte base for writes
- p0_ce, p0_we  in  1  port 0 enable / write enable
- p0_addr  in  ADDR_WID  port 0 word address
- p0_d  in  DATA_WID  port 0 write data
- p0_q  out  DATA_WID  port 0 read data
- p1_ce, p1_we, p1_addr, p1_d, p1_q: same as port 0, for port 1
- kernel_stall  out  1  kernel holds all state/outputs while high
- mem_rd_req  out  1  one-cycle read request pulse
- mem_rd_addr  out  64  read byte address
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  DATA_WID  read data
- mem_wr_req  out  1  one-cycle write request pulse
- mem_wr_addr  out  64  write byte address
- mem_wr_data  out  DATA_WID  write data
- mem_wr_ack  in  1  write complete
- timeout_err  out  1  sticky timeout flag
- busy  out  1  state != IDLE

Behaviour:
- Reset (async):
  - State → IDLE; captured requests dropped.
  - All outputs 0, including p0_q, p1_q and timeout_err.
- States: IDLE, P0_WAIT, P1_WAIT, RELEASE.
- Stall:
  - kernel_stall = (IDLE & (p0_ce | p1_ce)) | P0_WAIT | P1_WAIT. Combinational; RELEASE gives 0.
  - Kernel keeps ce/we/addr/d stable while stalled.
- IDLE, any ce high:
  - Capture we/addr/d of both ports plus pend0 = p0_ce, pend1 = p1_ce.
  - If pend0, go to P0_WAIT; else go to P1_WAIT.
- Entry to a wait state: issue one request pulse for that port, the cycle after capture.
  - Read: mem_rd_req = 1, mem_rd_addr = read_base + (addr << ADDR_SHIFT), 64-bit modulo.
  - Write: mem_wr_req = 1, mem_wr_addr = write_base + (addr << ADDR_SHIFT), mem_wr_data = captured d.
  - Address/data held stable until completion.
- Completion:
  - Read: first mem_rd_valid sampled on or after the cycle after the request pulse. Load pX_q with mem_rd_data.
  - Write: first mem_wr_ack, same sampling rule.
  - Valid/ack in the request cycle, or in IDLE/RELEASE, is ignored.
- P0_WAIT done: go to P1_WAIT if pend1, else RELEASE.
- P1_WAIT done: go to RELEASE.
- RELEASE:
  - One cycle with stall low; ce is ignored because it still reflects the serviced access.
  - Next state is IDLE.
- Read data visibility: pX_q holds from the RELEASE cycle until the next read on that port completes (BRAM-like, 1-cycle latency seen by the kernel). Writes leave pX_q unchanged.
- Wait counter:
  - Cleared on wait entry, +1 per wait cycle.
  - When it reaches TIMEOUT, the access completes as aborted: read returns 0, write is dropped, timeout_err is set until reset.
- Latency:
  - Single access = capture + 1 + memory latency + RELEASE.
  - Both ports = serial sum of the two accesses.
- Same address, both ports written: port 1 data is written last and wins.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds 32-bit outputs rd_count, wr_count, stall_count.
  - rd_count/wr_count +1 per completed (non-aborted) read/write.
  - stall_count +1 per cycle with kernel_stall = 1.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 read, addr 5, read_base 0x1000, memory valid 3 cycles after req:
  - mem_rd_addr = 0x1014 with a single req pulse.
  - Stall for capture + 4 cycles, then RELEASE; p0_q = returned data.
- Both ports active (p0 write addr 2 d 0xAA; p1 read addr 3):
  - Write serviced first (mem_wr_addr = write_base + 8), then the read.
  - Exactly one RELEASE; p1_q updated, p0_q unchanged.
- mem_rd_valid asserted in the same cycle as mem_rd_req: ignored; completion only on a later valid.
- No response for TIMEOUT = 1023 cycles: access aborts, p0_q = 0, timeout_err = 1 and stays 1 through later accesses.
- Reset asserted in P1_WAIT:
  - All outputs 0 immediately (async), state IDLE.
  - After deassert, a new request completes normally.
- STATS_EN build, 3 reads + 2 writes: rd_count = 3, wr_count = 2, stall_count equals the measured stall-high cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Serialises the two BRAM-style kernel ports onto one external memory channel, stalling the kernel meanwhile.
// Optional statistics counters are enabled by defining MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WID   = 14,
  parameter int DATA_WID   = 32,
  parameter int ADDR_SHIFT = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                mod_clk,
  input  logic                reset,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic                p0_ce,
  input  logic                p0_we,
  input  logic [ADDR_WID-1:0] p0_addr,
  input  logic [DATA_WID-1:0] p0_d,
  output logic [DATA_WID-1:0] p0_q,
  input  logic                p1_ce,
  input  logic                p1_we,
  input  logic [ADDR_WID-1:0] p1_addr,
  input  logic [DATA_WID-1:0] p1_d,
  output logic [DATA_WID-1:0] p1_q,
  output logic                kernel_stall,
  output logic                mem_rd_req,
  output logic [63:0]         mem_rd_addr,
  input  logic                mem_rd_valid,
  input  logic [DATA_WID-1:0] mem_rd_data,
  output logic                mem_wr_req,
  output logic [63:0]         mem_wr_addr,
  output logic [DATA_WID-1:0] mem_wr_data,
  input  logic                mem_wr_ack,
  output logic                timeout_err,
  output logic                busy
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic [31:0]         stall_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, P0_WAIT, P1_WAIT, RELEASE} state_t;

  state_t              state, state_nxt;
  logic                in_wait, req_cycle, resp, tmo, done;
  logic                capture, issue, iss_we;
  logic [ADDR_WID-1:0] iss_addr;
  logic [DATA_WID-1:0] iss_d;
  logic                pend1, cur_we;
  logic                cap_we1;
  logic [ADDR_WID-1:0] cap_addr1;
  logic [DATA_WID-1:0] cap_d1;
  logic [CNT_W-1:0]    wait_cnt;

  function automatic logic [63:0] byte_addr(input logic [63:0] base,
                                            input logic [ADDR_WID-1:0] addr);
    return base + (64'(addr) << ADDR_SHIFT);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign in_wait   = (state == P0_WAIT) || (state == P1_WAIT);
  // Responses coinciding with the request pulse belong to no access of ours.
  assign req_cycle = mem_rd_req | mem_wr_req;
  assign resp      = in_wait & ~req_cycle & (cur_we ? mem_wr_ack : mem_rd_valid);
  assign tmo       = in_wait & ~resp & (wait_cnt == CNT_W'(TIMEOUT));
  assign done      = resp | tmo;

  assign kernel_stall = ~reset & (((state == IDLE) & (p0_ce | p1_ce)) | in_wait);
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    issue     = 1'b0;
    iss_we    = 1'b0;
    iss_addr  = '0;
    iss_d     = '0;
    case (state)
      IDLE: begin
        if (p0_ce | p1_ce) begin
          capture = 1'b1;
          issue   = 1'b1;
          if (p0_ce) begin
            state_nxt = P0_WAIT;
            iss_we    = p0_we;
            iss_addr  = p0_addr;
            iss_d     = p0_d;
          end else begin
            state_nxt = P1_WAIT;
            iss_we    = p1_we;
            iss_addr  = p1_addr;
            iss_d     = p1_d;
          end
        end
      end
      P0_WAIT: begin
        if (done) begin
          if (pend1) begin
            state_nxt = P1_WAIT;
            issue     = 1'b1;
            iss_we    = cap_we1;
            iss_addr  = cap_addr1;
            iss_d     = cap_d1;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      P1_WAIT: if (done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request issue stage: pulses and addresses register on the transition into a wait state.
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      cur_we      <= 1'b0;
      pend1       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      mem_rd_req <= issue & ~iss_we;
      mem_wr_req <= issue & iss_we;
      if (issue) begin
        cur_we   <= iss_we;
        wait_cnt <= '0;
        if (iss_we) begin
          mem_wr_addr <= byte_addr(write_base, iss_addr);
          mem_wr_data <= iss_d;
        end else begin
          mem_rd_addr <= byte_addr(read_base, iss_addr);
        end
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (capture) pend1 <= p1_ce;
    end
  end

  always_ff @(posedge mod_clk) begin
    if (capture) begin
      cap_we1   <= p1_we;
      cap_addr1 <= p1_addr;
      cap_d1    <= p1_d;
    end
  end

  // Completion stage: read data lands in the port register; aborted reads return zero.
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      p0_q        <= '0;
      p1_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done && !cur_we && state == P0_WAIT) p0_q <= resp ? mem_rd_data : '0;
      if (done && !cur_we && state == P1_WAIT) p1_q <= resp ? mem_rd_data : '0;
      if (tmo) timeout_err <= 1'b1;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (resp && !cur_we) rd_count <= sat_inc(rd_count);
      if (resp && cur_we)  wr_count <= sat_inc(wr_count);
      if (kernel_stall)    stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter: the bench plays both kernel and memory.
module tb_mem_port_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int SH  = 2;
  localparam int TMO = 1023;

  logic          mod_clk = 1'b0;
  logic          reset;
  logic [63:0]   read_base, write_base;
  logic          p0_ce, p0_we, p1_ce, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_d, p1_d, p0_q, p1_q;
  logic          kernel_stall, mem_rd_req, mem_rd_valid, mem_wr_req, mem_wr_ack;
  logic          timeout_err, busy;
  logic [63:0]   mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0]   rd_count, wr_count, stall_count;
`endif

  mem_port_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .ADDR_SHIFT(SH), .TIMEOUT(TMO)) dut (
    .mod_clk(mod_clk), .reset(reset), .read_base(read_base), .write_base(write_base),
    .p0_ce(p0_ce), .p0_we(p0_we), .p0_addr(p0_addr), .p0_d(p0_d), .p0_q(p0_q),
    .p1_ce(p1_ce), .p1_we(p1_we), .p1_addr(p1_addr), .p1_d(p1_d), .p1_q(p1_q),
    .kernel_stall(kernel_stall), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .timeout_err(timeout_err), .busy(busy)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .stall_count(stall_count)
`endif
  );

  always #5 mod_clk = ~mod_clk;

  int n_vec = 0, n_err = 0;
  int stall_cyc = 0, rel_cyc = 0, req_cnt = 0, stall_tot = 0;
  logic [DW-1:0] mdl_q [2];
  bit mdl_tmo;
  int mdl_rd, mdl_wr;

  always @(negedge mod_clk) begin
    if (kernel_stall) stall_cyc++;
    if (busy && !kernel_stall) rel_cyc++;
    if (mem_rd_req || mem_wr_req) req_cnt++;
    if (reset) stall_tot = 0;
    else if (kernel_stall) stall_tot++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_addr(input logic [63:0] base, input logic [AW-1:0] a);
    return base + 64'(a) * (64'd1 << SH);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, kernel_stall, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_req"}, mem_rd_req, 0);
    chk({tag, "_wr_req"}, mem_wr_req, 0);
    chk({tag, "_rd_addr"}, mem_rd_addr, 0);
    chk({tag, "_wr_addr"}, mem_wr_addr, 0);
    chk({tag, "_wr_data"}, mem_wr_data, 0);
    chk({tag, "_p0_q"}, p0_q, 0);
    chk({tag, "_p1_q"}, p1_q, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk({tag, "_rd_count"}, rd_count, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_stall_count"}, stall_count, 0);
`endif
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mod_clk);
      if (mem_rd_req || mem_wr_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One kernel step: both enabled ports are serviced, port 0 first, then exactly one release cycle.
  task automatic kernel_op(input bit [1:0] ce, input bit [1:0] we,
                           input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           input int lat0, input int lat1, input bit early, input bit noresp);
    bit ok, w;
    int s0, r0, q0, exp_st, ntx, lat;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    @(posedge mod_clk); #1;
    p0_ce = ce[0]; p0_we = we[0]; p0_addr = a0; p0_d = d0;
    p1_ce = ce[1]; p1_we = we[1]; p1_addr = a1; p1_d = d1;
    s0 = stall_cyc; r0 = rel_cyc; q0 = req_cnt; exp_st = 1; ntx = 0;
    for (int p = 0; p < 2; p++) begin
      if (ce[p]) begin
        w = we[p]; a = p ? a1 : a0; d = p ? d1 : d0; lat = p ? lat1 : lat0;
        ntx++;
        wait_req(ok);
        chk($sformatf("p%0d_req_seen", p), ok, 1);
        if (!ok) break;
        chk($sformatf("p%0d_wr_req", p), mem_wr_req, w);
        chk($sformatf("p%0d_rd_req", p), mem_rd_req, !w);
        if (w) begin
          chk($sformatf("p%0d_wr_addr", p), mem_wr_addr, exp_addr(write_base, a));
          chk($sformatf("p%0d_wr_data", p), mem_wr_data, d);
        end else begin
          chk($sformatf("p%0d_rd_addr", p), mem_rd_addr, exp_addr(read_base, a));
        end
        if (noresp) begin
          if (!w) mdl_q[p] = '0;
          mdl_tmo = 1'b1;
        end else begin
          rd = $urandom;
          if (early) begin
            if (w) mem_wr_ack = 1'b1;
            else begin mem_rd_valid = 1'b1; mem_rd_data = ~rd; end
          end
          for (int k = 0; k < lat; k++) begin
            @(posedge mod_clk); #1;
            mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; mem_rd_data = $urandom;
          end
          if (w) mem_wr_ack = 1'b1;
          else begin mem_rd_valid = 1'b1; mem_rd_data = rd; end
          @(posedge mod_clk); #1;
          mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
          if (w) mdl_wr++;
          else begin mdl_rd++; mdl_q[p] = rd; end
          exp_st += 1 + lat;
        end
      end
    end
    ok = 1'b0;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge mod_clk);
      if (!kernel_stall) begin ok = 1'b1; break; end
    end
    chk("release_reached", ok, 1);
    chk("release_busy", busy, 1);
    chk("p0_q", p0_q, mdl_q[0]);
    chk("p1_q", p1_q, mdl_q[1]);
    chk("timeout_err", timeout_err, mdl_tmo);
    p0_ce = 1'b0; p1_ce = 1'b0;
    @(negedge mod_clk);
    chk("idle_busy", busy, 0);
    chk("idle_stall", kernel_stall, 0);
    chk("release_cycles", rel_cyc - r0, 1);
    chk("req_pulses", req_cnt - q0, ntx);
    if (!noresp) chk("stall_cycles", stall_cyc - s0, exp_st);
  endtask

  initial begin
    bit ok;
    bit [1:0] ce;
    logic [AW-1:0] ra0, ra1;
    reset = 1'b1;
    read_base = '0; write_base = '0;
    p0_ce = 0; p0_we = 0; p0_addr = '0; p0_d = '0;
    p1_ce = 0; p1_we = 0; p1_addr = '0; p1_d = '0;
    mem_rd_valid = 0; mem_rd_data = '0; mem_wr_ack = 0;
    mdl_q[0] = '0; mdl_q[1] = '0; mdl_tmo = 0; mdl_rd = 0; mdl_wr = 0;
    repeat (3) @(negedge mod_clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Directed cases
    read_base = 64'h1000; write_base = 64'h2000;
    kernel_op(2'b01, 2'b00, 14'd5, '0, '0, '0, 3, 1, 1'b0, 1'b0);
    kernel_op(2'b11, 2'b01, 14'd2, 32'hAA, 14'd3, '0, 2, 4, 1'b0, 1'b0);
    kernel_op(2'b01, 2'b00, 14'd9, '0, '0, '0, 2, 1, 1'b1, 1'b0);
    kernel_op(2'b10, 2'b00, '0, '0, 14'd11, '0, 1, 1, 1'b1, 1'b0);
    kernel_op(2'b11, 2'b11, 14'd7, 32'h1111, 14'd7, 32'h2222, 1, 2, 1'b0, 1'b0);
    read_base = 64'hFFFF_FFFF_FFFF_FFF0; write_base = 64'hFFFF_FFFF_FFFF_FF00;
    kernel_op(2'b11, 2'b10, 14'h3FFF, '0, 14'h3FFF, 32'h55, 1, 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      read_base  = {$urandom, $urandom};
      write_base = {$urandom, $urandom};
      ce = 2'($urandom_range(1, 3));
      ra0 = AW'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : AW'($urandom);
      kernel_op(ce, 2'($urandom), ra0, $urandom, ra1, $urandom,
                $urandom_range(1, 5), $urandom_range(1, 5), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Abort path, then the flag must survive later good accesses
    kernel_op(2'b01, 2'b00, 14'd4, '0, '0, '0, 2, 1, 1'b0, 1'b0);
    kernel_op(2'b01, 2'b00, 14'd4, '0, '0, '0, 1, 1, 1'b0, 1'b1);
    kernel_op(2'b10, 2'b10, '0, '0, 14'd6, 32'h77, 1, 3, 1'b0, 1'b0);
    kernel_op(2'b01, 2'b00, 14'd8, '0, '0, '0, 2, 1, 1'b0, 1'b0);

    // Asynchronous reset while port 1 waits for its response
    @(posedge mod_clk); #1;
    p1_ce = 1'b1; p1_we = 1'b0; p1_addr = 14'd12;
    wait_req(ok);
    chk("rst_req_seen", ok, 1);
    @(posedge mod_clk); #3;
    chk("rst_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_p1");
    p1_ce = 1'b0;
    mdl_q[0] = '0; mdl_q[1] = '0; mdl_tmo = 0; mdl_rd = 0; mdl_wr = 0;
    repeat (2) @(negedge mod_clk);
    reset = 1'b0;
    kernel_op(2'b10, 2'b00, '0, '0, 14'd12, '0, 2, 2, 1'b0, 1'b0);
    kernel_op(2'b11, 2'b10, 14'd1, '0, 14'd2, 32'h99, 1, 1, 1'b0, 1'b0);
    kernel_op(2'b01, 2'b00, 14'd3, '0, '0, '0, 3, 1, 1'b0, 1'b0);
    kernel_op(2'b01, 2'b01, 14'd4, 32'h44, '0, '0, 1, 1, 1'b0, 1'b0);

`ifdef MEM_PORT_ARBITER_STATS_EN
    repeat (2) @(negedge mod_clk);
    chk("rd_count", rd_count, mdl_rd);
    chk("wr_count", wr_count, mdl_wr);
    chk("stall_count", stall_count, stall_tot);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
